// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: datapath widths and the write-back queue entry format.
package lc4_pkg;

  localparam int unsigned LC4_DATA_W   = 16;
  localparam int unsigned LC4_REG_W    = 3;
  localparam int unsigned LC4_NUM_REGS = 8;

  typedef struct packed {
    logic [LC4_REG_W-1:0]  rd;
    logic [LC4_DATA_W-1:0] data;
  } wbq_entry_t;

  function automatic logic [LC4_NUM_REGS-1:0] reg_onehot(input logic [LC4_REG_W-1:0] r);
    return LC4_NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/lc4_div_wb_queue_if.sv
// Execute-side push handshake plus register-file write port of the DIV/MOD write-back queue.
interface lc4_div_wb_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
);
  import lc4_pkg::*;

  logic                    i_valid;
  logic                    o_ready;
  logic                    i_is_mod;
  logic [LC4_REG_W-1:0]    i_rd;
  logic [LC4_DATA_W-1:0]   i_quotient;
  logic [LC4_DATA_W-1:0]   i_remainder;
  logic                    i_wb_free;
  logic                    o_we;
  logic [LC4_REG_W-1:0]    o_wsel;
  logic [LC4_DATA_W-1:0]   o_wdata;
  logic [LC4_NUM_REGS-1:0] o_pending_mask;
  logic [PTR_W:0]          o_count;

  modport master (
    output i_valid, i_is_mod, i_rd, i_quotient, i_remainder, i_wb_free,
    input  o_ready, o_we, o_wsel, o_wdata, o_pending_mask, o_count
  );

  modport slave (
    input  i_valid, i_is_mod, i_rd, i_quotient, i_remainder, i_wb_free,
    output o_ready, o_we, o_wsel, o_wdata, o_pending_mask, o_count
  );

endinterface

// File: rtl/lc4_wbq_storage.sv
// Entry array for the write-back queue: one write port, one combinational read port,
// and a per-entry valid vector whose destination registers feed the pending mask.
module lc4_wbq_storage
  import lc4_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [PTR_W-1:0]     wr_ptr,
  input  wbq_entry_t           wr_entry,
  input  logic                 clr_en,
  input  logic [PTR_W-1:0]     clr_ptr,
  input  logic [PTR_W-1:0]     rd_ptr,
  output wbq_entry_t           rd_entry,
  output logic [LC4_REG_W-1:0] ent_rd [DEPTH],
  output logic [DEPTH-1:0]     valid
);

  wbq_entry_t       mem [DEPTH];
  logic [DEPTH-1:0] valid_nxt;

  // Entry payload write; contents are never observed unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // Valid bit update: clear on pop, set on push (never the same slot in one cycle).
  always_comb begin
    valid_nxt = valid;
    if (clr_en) valid_nxt[clr_ptr] = 1'b0;
    if (wr_en)  valid_nxt[wr_ptr]  = 1'b1;
  end

  // Valid vector register, discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else        valid <= valid_nxt;
  end

  // Read port and per-entry destination view.
  always_comb begin
    rd_entry = mem[rd_ptr];
    for (int unsigned i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
  end

endmodule

// File: rtl/lc4_div_wb_queue.sv
// In-order write-back queue for committed LC4 DIV/MOD results. Drains into the
// register-file write port on cycles the main pipeline leaves it free.
module lc4_div_wb_queue
  import lc4_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic                clk,
  input logic                rst_n,
  input logic                gwe,
  lc4_div_wb_queue_if.slave  q
);

  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [PTR_W:0]       count_q;
  logic                 ready;
  logic                 not_empty;
  logic                 push;
  logic                 pop;
  wbq_entry_t           wr_entry;
  wbq_entry_t           head_entry;
  logic [LC4_REG_W-1:0] ent_rd [DEPTH];
  logic [DEPTH-1:0]     valid;

  lc4_wbq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_ptr   (tail_q),
    .wr_entry (wr_entry),
    .clr_en   (pop),
    .clr_ptr  (head_q),
    .rd_ptr   (head_q),
    .rd_entry (head_entry),
    .ent_rd   (ent_rd),
    .valid    (valid)
  );

  // Handshake: readiness depends only on registered count, so a full queue refuses
  // a push even when it pops in the same cycle.
  always_comb begin
    ready     = (count_q != (PTR_W+1)'(DEPTH));
    not_empty = (count_q != '0);
    push      = q.i_valid && ready && gwe;
    pop       = not_empty && q.i_wb_free && gwe;
    wr_entry  = '{rd: q.i_rd, data: (q.i_is_mod ? q.i_remainder : q.i_quotient)};
  end

  // Outputs: head entry shown only while non-empty; mask is the OR of valid destinations.
  always_comb begin
    q.o_ready        = ready;
    q.o_we           = pop;
    q.o_count        = count_q;
    q.o_wsel         = not_empty ? head_entry.rd   : '0;
    q.o_wdata        = not_empty ? head_entry.data : '0;
    q.o_pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) q.o_pending_mask = q.o_pending_mask | reg_onehot(ent_rd[i]);
    end
  end

  // Pointer and occupancy state; pointers wrap naturally, full/empty come from count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/lc4_div_wb_queue.md
Name: lc4_div_wb_queue

Overview:
Downstream neighbour of the combinational LC4 divider in the execute stage. Captures committed DIV/MOD results, each with its destination register, in a small in-order FIFO. Drains them into the register-file write port on cycles when the main pipeline leaves that port free. Exports a pending-register mask so decode can stall consumers of results not yet written.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
gwe  input  1  global write enable; state advances only when 1
i_valid  input  1  execute stage presents a committed DIV/MOD result
o_ready  output  1  queue can accept an entry this cycle
i_is_mod  input  1  1 = MOD (write remainder), 0 = DIV (write quotient)
i_rd  input  3  destination register
i_quotient  input  16  divider quotient output
i_remainder  input  16  divider remainder output
i_wb_free  input  1  register-file write port is unused by the main pipeline this cycle
o_we  output  1  register-file write enable from the queue
o_wsel  output  3  register-file write select
o_wdata  output  16  register-file write data
o_pending_mask  output  8  bit r = 1 if any valid entry targets register r
o_count  output  PTR_W+1  number of valid entries

Behaviour:
- Reset: rst_n low asynchronously clears head pointer, tail pointer and count. All outputs settle to: o_ready=1, o_we=0, o_wsel=0, o_wdata=0, o_pending_mask=0, o_count=0. Entry storage contents are don't-care but must never be visible.
- Data selection at push: stored data = i_is_mod ? i_remainder : i_quotient. Only 16 data bits + 3 rd bits are stored per entry.
- Divide-by-zero: the divider already produces 0/0. The queue passes the value through unchanged; no special case.
- Push: occurs when i_valid && o_ready && gwe. Entry is written at tail; tail increments modulo DEPTH; count increments.
- o_ready = (count != DEPTH). This is a registered-state function only; it does not depend on same-cycle pop. When full, a push is refused even if a pop happens that cycle.
- i_valid while o_ready=0: upstream holds i_valid and its operands; the queue ignores them.
- Pop: o_we = (count != 0) && i_wb_free && gwe, combinational. o_wsel/o_wdata show the head entry whenever count != 0, and 0 when empty. When o_we=1, head increments modulo DEPTH on the clock edge and count decrements.
- Latency: a push into an empty queue is visible at the head the next cycle. The earliest o_we is therefore 1 cycle after the push; there is no same-cycle fall-through.
- Simultaneous push and pop (0 < count < DEPTH): both occur, count is unchanged, and both pointers advance.
- Ordering: strictly FIFO. Duplicate rd values are legal; later entries overwrite earlier ones in register order.
- Pending mask: OR over all valid entries of onehot(rd), computed from registered state. A register's bit clears the cycle after its last entry pops.
- gwe=0: no push, no pop, o_we=0, all state held. o_ready, o_pending_mask and o_count still reflect current state.
- Pointer wrap: pointers are PTR_W bits and wrap naturally. Full/empty are determined from count, not pointer equality.
- Reset mid-operation: queued entries are discarded. No write is issued after rst_n deasserts until a new push arrives.

Decomposition:
- Shared package lc4_pkg holds: LC4_DATA_W=16, LC4_REG_W=3, LC4_NUM_REGS=8, and typedef wbq_entry_t {rd[2:0], data[15:0]}.
- One sub-module, lc4_wbq_storage: a DEPTH x 19-bit register array with one write port (enable, pointer, entry), one combinational read port (pointer), and a per-entry valid vector used for the pending mask. The top level holds pointers, count, handshake logic and the mask reduction.

Test Plan:
- Reset, then push DIV 100/7 to rd=3 with i_wb_free=1 -> next cycle o_we=1, o_wsel=3, o_wdata=14; o_pending_mask=0x08 during the queued cycle, 0x00 after.
- Push MOD 100/7 to rd=5 and MOD 5/0 to rd=1 with i_wb_free=0 -> count=2, mask=0x22. Then raise i_wb_free -> writes (5,2) then (1,0) in order.
- Hold i_wb_free=0 and push 4 entries -> o_ready=0 and count=4. A 5th push is held with no state change. Raise i_wb_free with i_valid still high -> pop that cycle, push accepted the following cycle.
- With count=2, push and pop in the same cycle -> count stays 2; exactly one write issued; data order preserved across pointer wrap after 10 such cycles.
- gwe=0 for 3 cycles with i_valid=1 and i_wb_free=1 -> o_we=0 and count unchanged. Restoring gwe=1 resumes normal operation.
- Assert rst_n=0 mid-cycle with 3 entries queued -> outputs clear immediately without waiting for clk; no writes after release.
